// File: rtl/iqueue_ring.sv
// iqueue_ring: circular instruction queue between fetch aligner and issue,
// taking up to FETCH_WIDTH entries per cycle and presenting the oldest ISSUE_WIDTH.
module iqueue_ring #(
    parameter int          FETCH_WIDTH = 10,
    parameter int          ISSUE_WIDTH = 4,
    parameter int          DEPTH       = 16,
    parameter int          ENTRY_W     = 96,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013,
    parameter bit          PAD_NOP     = 1'b1,
    localparam int         CW          = $clog2(FETCH_WIDTH + 1),
    localparam int         PW          = $clog2(DEPTH),
    localparam int         NW          = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_fetchValid,
    input  logic [CW-1:0]                  i_fetchCnt,
    input  logic [FETCH_WIDTH*ENTRY_W-1:0] i_fetchEntries,
    output logic                           o_fetchReady,
    input  logic                           i_flush,
    input  logic                           i_issueReady,
    output logic [ISSUE_WIDTH-1:0]         o_issueValid,
    output logic [ISSUE_WIDTH*ENTRY_W-1:0] o_issueEntries,
    output logic [NW-1:0]                  o_count
);
    localparam logic [ENTRY_W-1:0] PAD = PAD_NOP ? ENTRY_W'(NOP_INSTR) : '0;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      head, tail;
    logic [NW-1:0]      count, push, pop;
    logic [CW-1:0]      n;
    logic               enq, clear;

    always_comb begin
        n     = i_fetchCnt > CW'(FETCH_WIDTH) ? CW'(FETCH_WIDTH) : i_fetchCnt;
        clear = rst || i_flush;
        enq   = i_fetchValid && o_fetchReady && n != '0 && !clear;
        push  = enq ? NW'(n) : '0;
        pop   = !i_issueReady ? '0 : count < NW'(ISSUE_WIDTH) ? count : NW'(ISSUE_WIDTH);
    end

    // Ready looks only at registered occupancy; a same-cycle pop earns no credit.
    assign o_fetchReady = count <= NW'(DEPTH - FETCH_WIDTH);
    assign o_count      = count;

    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push);
            count <= count + push - pop;
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            for (int k = 0; k < FETCH_WIDTH; k++)
                if (CW'(k) < n) mem[tail + PW'(k)] <= i_fetchEntries[k*ENTRY_W +: ENTRY_W];
    end

    // Slots beyond the occupancy show the pad pattern rather than stale storage.
    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_issue
        logic [PW-1:0] rd;
        assign rd                                  = head + PW'(k);
        assign o_issueValid[k]                     = NW'(k) < count;
        assign o_issueEntries[k*ENTRY_W +: ENTRY_W] = o_issueValid[k] ? mem[rd] : PAD;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= NW'(DEPTH));
endmodule
